// File: rtl/softmax_pkg.sv
`default_nettype none
// ============================================================================
// Module   : softmax_pkg
// Purpose  : Types, constants and helpers shared by the softmax P*V
//            accumulation stage.
// Contents : pv_state_t - control state encoding
//            SCALE_ONE  - Q1.15 value of 1.0 (largest legal rescale factor)
//            acc_w()    - accumulator width for a given word width / tile size
//            sat_d_w()  - clamp a value to a signed d_w-bit range
// Revision : 1.0 - initial release
// ============================================================================
package softmax_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCALE = 2'd1,
    S_MAC   = 2'd2,
    S_OUT   = 2'd3
  } pv_state_t;

  localparam logic [15:0] SCALE_ONE = 16'h8000;

  // Two D_W-bit factors, NUM terms summed, plus headroom for the sign
  // bit of the unsigned probability and the signed result.
  function automatic int acc_w(input int d_w, input int num);
    return 2 * d_w + $clog2(num) + 2;
  endfunction

  function automatic longint sat_d_w(input longint x, input int d_w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (d_w - 1)) - 1;
    lo = -(longint'(1) <<< (d_w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pv_mac_lane.sv
`default_nettype none
// ============================================================================
// Module   : pv_mac_lane
// Purpose  : One output column of the P*V accumulation: holds the running
//            accumulator, rescales it by a Q1.15 factor and adds P*V terms.
// Ports    : clk, rst_n   - clock, async active-low reset
//            clr, zero    - synchronous clear of the accumulator
//            scale_en     - apply acc <- (acc * scale) >>> 15 this cycle
//            scale        - Q1.15 factor, already clamped to <= 1.0
//            mac_en       - apply acc <- acc + p * v this cycle
//            p            - unsigned probability word
//            v            - signed V element
//            acc          - accumulator value
// Revision : 1.0 - initial release
// ============================================================================
module pv_mac_lane #(
  parameter int D_W   = 8,
  parameter int ACC_W = 22
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    zero,
  input  logic                    scale_en,
  input  logic [15:0]             scale,
  input  logic                    mac_en,
  input  logic [D_W-1:0]          p,
  input  logic [D_W-1:0]          v,
  output logic signed [ACC_W-1:0] acc
);

  localparam int PW = ACC_W + 17;

  logic signed [PW-1:0]     acc_ext;
  logic signed [PW-1:0]     scale_ext;
  logic signed [PW-1:0]     scale_prod;
  logic signed [ACC_W-1:0]  acc_scaled;
  logic signed [2*D_W:0]    p_ext;
  logic signed [2*D_W:0]    v_ext;
  logic signed [2*D_W:0]    mac_prod;
  logic signed [ACC_W-1:0]  mac_ext;

  // Rescale: the factor is zero-extended so 0x8000 stays +1.0; the product
  // is wide enough to be exact, and >>> gives floor rounding.
  assign acc_ext    = {{17{acc[ACC_W-1]}}, acc};
  assign scale_ext  = {{(ACC_W + 1){1'b0}}, scale};
  assign scale_prod = acc_ext * scale_ext;
  assign acc_scaled = ACC_W'(scale_prod >>> 15);

  // P is unsigned, V signed: P gets a zero top bit before the signed multiply.
  assign p_ext    = {{(D_W + 1){1'b0}}, p};
  assign v_ext    = {{(D_W + 1){v[D_W-1]}}, v};
  assign mac_prod = p_ext * v_ext;
  assign mac_ext  = {{(ACC_W - 2 * D_W - 1){mac_prod[2*D_W]}}, mac_prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr || zero) begin
      acc <= '0;
    end else if (scale_en) begin
      acc <= acc_scaled;
    end else if (mac_en) begin
      acc <= acc + mac_ext;
    end
  end

endmodule
`default_nettype wire

// File: rtl/softmax_pv_accum.sv
`default_nettype none
// ============================================================================
// Module   : softmax_pv_accum
// Purpose  : Accumulates one attention output row P*V over successive key
//            tiles, rescaling the running sum before each non-first tile, and
//            emits a saturated HEAD_D-wide row after the last tile.
// Ports    : I_CLK, I_RST_N - clock, async active-low reset
//            I_CLR          - synchronous abort; returns to idle, clears acc
//            I_TILE_VLD     - tile offered (held until accepted)
//            O_READY        - block is idle and can take a tile
//            I_FIRST/I_LAST - tile position within the row
//            I_SCALE        - Q1.15 rescale factor, clamped to 1.0
//            I_P, I_V       - probability row and V tile
//            O_VLD, O_DATA  - one-cycle output strobe and held output row
// Revision : 1.0 - initial release
// ============================================================================
module softmax_pv_accum
  import softmax_pkg::*;
#(
  parameter int D_W    = 8,
  parameter int NUM    = 16,
  parameter int HEAD_D = 16
) (
  input  logic           I_CLK,
  input  logic           I_RST_N,
  input  logic           I_CLR,
  input  logic           I_TILE_VLD,
  output logic           O_READY,
  input  logic           I_FIRST,
  input  logic           I_LAST,
  input  logic [15:0]    I_SCALE,
  input  logic [D_W-1:0] I_P [0:NUM-1],
  input  logic [D_W-1:0] I_V [0:NUM-1][0:HEAD_D-1],
  output logic           O_VLD,
  output logic [D_W-1:0] O_DATA [0:HEAD_D-1]
);

  localparam int             ACC_W  = acc_w(D_W, NUM);
  localparam int             KW     = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [KW-1:0]  K_LAST = KW'(NUM - 1);

  pv_state_t               state_q;
  pv_state_t               state_d;
  logic [KW-1:0]           k_q;
  logic                    last_q;
  logic [15:0]             scale_q;
  logic [D_W-1:0]          p_q [0:NUM-1];
  logic [D_W-1:0]          v_q [0:NUM-1][0:HEAD_D-1];
  logic signed [ACC_W-1:0] acc [0:HEAD_D-1];
  logic                    accept;

  // Clear wins over an offered tile.
  assign accept  = (state_q == S_IDLE) && I_TILE_VLD && !I_CLR;
  assign O_READY = (state_q == S_IDLE);

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (I_CLR) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (I_TILE_VLD) state_d = I_FIRST ? S_MAC : S_SCALE;
        S_SCALE: state_d = S_MAC;
        S_MAC:   if (k_q == K_LAST) state_d = last_q ? S_OUT : S_IDLE;
        S_OUT:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Tap counter and the per-tile control latches.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      k_q     <= '0;
      last_q  <= 1'b0;
      scale_q <= '0;
    end else begin
      if (I_CLR) begin
        k_q <= '0;
      end else if (state_q == S_MAC) begin
        k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
      end
      if (accept) begin
        last_q  <= I_LAST;
        scale_q <= (I_SCALE > SCALE_ONE) ? SCALE_ONE : I_SCALE;
      end
    end
  end

  // Tile data is only read while a tile is in flight, so it needs no reset.
  always_ff @(posedge I_CLK) begin
    if (accept) begin
      p_q <= I_P;
      v_q <= I_V;
    end
  end

  for (genvar g = 0; g < HEAD_D; g++) begin : g_lane
    pv_mac_lane #(
      .D_W   (D_W),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk      (I_CLK),
      .rst_n    (I_RST_N),
      .clr      (I_CLR),
      .zero     (accept && I_FIRST),
      .scale_en (state_q == S_SCALE),
      .scale    (scale_q),
      .mac_en   (state_q == S_MAC),
      .p        (p_q[k_q]),
      .v        (v_q[k_q][g]),
      .acc      (acc[g])
    );
  end

  // The accumulator carries D_W fraction bits from P; drop them with floor
  // rounding and clamp to the output word.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      O_VLD <= 1'b0;
      for (int d = 0; d < HEAD_D; d++) O_DATA[d] <= '0;
    end else begin
      O_VLD <= (state_q == S_OUT) && !I_CLR;
      if ((state_q == S_OUT) && !I_CLR) begin
        for (int d = 0; d < HEAD_D; d++) begin
          O_DATA[d] <= D_W'(sat_d_w(longint'(acc[d] >>> D_W), D_W));
        end
      end
    end
  end

endmodule
`default_nettype wire
